// File: rtl/aes_seq_pkg.sv
// aes_seq_pkg: FSM state encoding and datapath widths shared by aes_job_sequencer and its FIFO
package aes_seq_pkg;
  localparam int KEY_W = 256;
  localparam int BLK_W = 128;
  localparam int TMO_W = 16;
  typedef enum logic [2:0] {IDLE, KEY_INIT, KEY_WAIT, BLK_NEXT, BLK_WAIT, PUSH} state_t;
endpackage

// File: rtl/aes_seq_fifo.sv
// aes_seq_fifo: result FIFO with occupancy count; head reads as zero while empty
module aes_seq_fifo
  import aes_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = BLK_W
) (
  input  logic                   clk,
  input  logic                   aes_reset_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  // storage array; contents are only observed through the count-gated head
  always_ff @(posedge clk)
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge aes_reset_n)
    if (!aes_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      o_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      o_count <= o_count + CW'(i_push) - CW'(i_pop);
    end
  assign o_data = (o_count != '0) ? r_mem[r_rd_ptr] : '0;
endmodule

// File: rtl/aes_job_sequencer.sv
// aes_job_sequencer: runs one job at a time through an external aes_core and queues results.
// Optional last-key cache (skips key expansion on a repeat key) enabled by AES_SEQ_KEYCACHE_EN.
module aes_job_sequencer
  import aes_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic             clk,
  input  logic             aes_reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [KEY_W-1:0] in_key,
  input  logic             in_keylen,
  input  logic             in_encdec,
  input  logic [BLK_W-1:0] in_block,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_result,
  output logic             busy,
  output logic             err,
  output logic             core_init,
  output logic             core_next,
  output logic             core_encdec,
  output logic             core_keylen,
  output logic [KEY_W-1:0] core_key,
  output logic [BLK_W-1:0] core_block,
  input  logic             core_ready,
  input  logic             core_valid,
  input  logic [BLK_W-1:0] core_result
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]    DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [TMO_W-1:0] TMO_C   = TMO_W'(TIMEOUT);

  state_t           r_state;
  state_t           w_next;
  logic             r_run;
  logic             r_err;
  logic [KEY_W-1:0] r_key;
  logic             r_keylen;
  logic             r_encdec;
  logic [BLK_W-1:0] r_block;
  logic [BLK_W-1:0] r_result;
  logic [TMO_W-1:0] r_wait_cnt;
  logic [CW-1:0]    w_count;
  logic             w_accept;
  logic             w_hit;
  logic             w_wait;
  logic             w_core_ok;
  logic             w_tmo;
  logic             w_push;
  logic             w_pop;
  logic             w_unused;

  assign in_ready    = r_run && r_state == IDLE && w_count < DEPTH_C;
  assign w_accept    = in_valid && in_ready;
  assign w_wait      = r_state == KEY_WAIT || r_state == BLK_WAIT;
  assign w_core_ok   = w_wait && r_wait_cnt != '0 && core_ready;
  assign w_tmo       = w_wait && !w_core_ok && r_wait_cnt == TMO_C;
  assign w_push      = r_state == PUSH;
  assign w_pop       = out_valid && out_ready;
  assign out_valid   = w_count != '0;
  assign busy        = r_state != IDLE;
  assign err         = r_err;
  assign core_init   = r_state == KEY_INIT;
  assign core_next   = r_state == BLK_NEXT;
  assign core_key    = r_key;
  assign core_keylen = r_keylen;
  assign core_encdec = r_encdec;
  assign core_block  = r_block;
  // core_ready alone marks completion; core_valid carries no extra information here
  assign w_unused    = core_valid;

`ifdef AES_SEQ_KEYCACHE_EN
  logic             r_cache_vld;
  logic [KEY_W-1:0] r_cache_key;
  logic             r_cache_keylen;
  assign w_hit = r_cache_vld && in_key == r_cache_key && in_keylen == r_cache_keylen;
  // track the key the core currently holds expanded; a new init or a timeout makes it unknown
  always_ff @(posedge clk or negedge aes_reset_n)
    if (!aes_reset_n) begin
      r_cache_vld    <= 1'b0;
      r_cache_key    <= '0;
      r_cache_keylen <= 1'b0;
    end else if (w_tmo || core_init) begin
      r_cache_vld <= 1'b0;
    end else if (r_state == KEY_WAIT && w_core_ok) begin
      r_cache_vld    <= 1'b1;
      r_cache_key    <= r_key;
      r_cache_keylen <= r_keylen;
    end
`else
  assign w_hit = 1'b0;
`endif

  // next-state selection
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (w_accept) w_next = w_hit ? BLK_NEXT : KEY_INIT;
      KEY_INIT: w_next = KEY_WAIT;
      KEY_WAIT: w_next = w_core_ok ? BLK_NEXT : w_tmo ? IDLE : KEY_WAIT;
      BLK_NEXT: w_next = BLK_WAIT;
      BLK_WAIT: w_next = w_core_ok ? PUSH : w_tmo ? IDLE : BLK_WAIT;
      PUSH:     w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // state, post-reset run enable, sticky error and wait counter (zero on every wait entry)
  always_ff @(posedge clk or negedge aes_reset_n)
    if (!aes_reset_n) begin
      r_state    <= IDLE;
      r_run      <= 1'b0;
      r_err      <= 1'b0;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_next;
      r_run      <= 1'b1;
      if (w_tmo) r_err <= 1'b1;
      r_wait_cnt <= w_wait ? r_wait_cnt + 1'b1 : '0;
    end

  // job capture on accept and core result capture on block completion
  always_ff @(posedge clk or negedge aes_reset_n)
    if (!aes_reset_n) begin
      r_key    <= '0;
      r_keylen <= 1'b0;
      r_encdec <= 1'b0;
      r_block  <= '0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_key    <= in_key;
        r_keylen <= in_keylen;
        r_encdec <= in_encdec;
        r_block  <= in_block;
      end
      if (r_state == BLK_WAIT && w_core_ok) r_result <= core_result;
    end

  aes_seq_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(BLK_W)) u_fifo (
    .clk        (clk),
    .aes_reset_n(aes_reset_n),
    .i_push     (w_push),
    .i_data     (r_result),
    .i_pop      (w_pop),
    .o_data     (out_result),
    .o_count    (w_count)
  );
endmodule

// File: tb/tb_aes_job_sequencer.sv
// tb_aes_job_sequencer: table vectors, corner sequences and random jobs against a stand-in aes_core
module tb_aes_job_sequencer;
  localparam int DEPTH = 4;
  localparam int TMO   = 15;
  localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] P0   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;
`ifdef AES_SEQ_KEYCACHE_EN
  localparam int SAME_KEY_INITS = 1;
`else
  localparam int SAME_KEY_INITS = 2;
`endif

  logic clk = 0, aes_reset_n = 0;
  logic in_valid = 0, in_keylen = 0, in_encdec = 0, out_ready = 0;
  logic [255:0] in_key = '0;
  logic [127:0] in_block = '0;
  logic in_ready, out_valid, busy, err, core_init, core_next, core_encdec, core_keylen;
  logic [127:0] out_result, core_block;
  logic [255:0] core_key;
  logic core_ready = 1, core_valid = 0;
  logic [127:0] core_result = '0;

  int n_pass = 0, n_total = 0, init_cnt = 0, exp_inits = 0;
  logic mc_vld = 0, mc_kl = 0, hang = 0, m_kl = 0;
  logic [255:0] mc_key = '0, m_key = '0;
  int m_dly = 0;
  logic [127:0] q_exp[$];

  typedef struct {logic [255:0] key; logic kl; logic ed; logic [127:0] blk; logic [127:0] exp;} vec_t;
  vec_t tbl[6];
  logic [255:0] pool[3];

  always #5 clk = ~clk;

  aes_job_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .aes_reset_n(aes_reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key), .in_keylen(in_keylen),
    .in_encdec(in_encdec), .in_block(in_block),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .busy(busy), .err(err),
    .core_init(core_init), .core_next(core_next), .core_encdec(core_encdec),
    .core_keylen(core_keylen), .core_key(core_key), .core_block(core_block),
    .core_ready(core_ready), .core_valid(core_valid), .core_result(core_result)
  );

  // stand-in cipher: the two published AES vectors, otherwise a keyed scramble
  function automatic logic [127:0] ref_aes(input logic [255:0] k, input logic kl, input logic ed,
                                           input logic [127:0] b);
    logic [127:0] kk;
    if (k == K128 && !kl && ed && b == P0) return C128;
    if (k == K256 && kl && !ed && b == C256) return P0;
    kk = kl ? k[255:128] ^ k[127:0] : k[255:128];
    return {b[62:0], b[127:63]} ^ kk ^ (ed ? {4{32'h5a5a0f0f}} : {4{32'h3c3cc3c3}});
  endfunction

  // aes_core model: uses the key latched at init, so a wrongly skipped init gives a wrong result
  always @(negedge clk) begin
    if (!aes_reset_n) begin
      core_ready = 1; core_valid = 0; m_dly = 0;
    end else if (core_init) begin
      m_key = core_key; m_kl = core_keylen; core_ready = 0; core_valid = 0;
      m_dly = $urandom_range(1, 4); init_cnt++;
    end else if (core_next) begin
      core_result = ref_aes(m_key, m_kl, core_encdec, core_block);
      core_ready = 0; core_valid = 0; m_dly = $urandom_range(1, 4);
    end else if (!core_ready && !hang) begin
      if (m_dly == 0) begin core_ready = 1; core_valid = 1; end
      else m_dly--;
    end
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // offer one job; ok=0 means the core will hang so no result and no cached key are expected
  task automatic send_job(input logic [255:0] k, input logic kl, input logic ed,
                          input logic [127:0] b, input logic ok);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 300) begin @(negedge clk); t++; end
    if (!in_ready) begin check("in_ready_wait", 128'(in_ready), 128'd1); return; end
    in_valid = 1; in_key = k; in_keylen = kl; in_encdec = ed; in_block = b;
    @(posedge clk); #1 in_valid = 0;
    if (ok) q_exp.push_back(ref_aes(k, kl, ed, b));
`ifdef AES_SEQ_KEYCACHE_EN
    if (!(mc_vld && mc_key == k && mc_kl == kl)) begin
      exp_inits++; mc_vld = ok; mc_key = k; mc_kl = kl;
    end
`else
    exp_inits++;
`endif
  endtask

  task automatic wait_out(input string name);
    int t = 0;
    @(negedge clk);
    while (!out_valid && t < 200) begin @(negedge clk); t++; end
    if (!out_valid) check(name, 128'(out_valid), 128'd1);
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    @(negedge clk);
    while (busy && t < 200) begin @(negedge clk); t++; end
    if (busy) check(name, 128'(busy), 128'd0);
  endtask

  // compare the head against exp, then pop it
  task automatic pop_cmp(input string name, input logic [127:0] exp);
    logic [127:0] d;
    check(name, out_result, exp);
    if (q_exp.size() != 0) d = q_exp.pop_front();
    out_ready = 1;
    @(posedge clk); #1 out_ready = 0;
  endtask

  task automatic pop_one(input string name);
    check(name, out_result, q_exp.size() != 0 ? q_exp[0] : 'x);
    pop_cmp(name, out_result);
    n_total--; n_pass--;
  endtask

  task automatic do_reset();
    @(negedge clk);
    aes_reset_n = 0; in_valid = 0; out_ready = 0;
    #1;
    check("rst_ctrl", 128'({in_ready, out_valid, busy, err, core_init, core_next, core_encdec, core_keylen}), 128'd0);
    check("rst_key_hi", core_key[255:128], '0);
    check("rst_key_lo", core_key[127:0], '0);
    check("rst_block", core_block, '0);
    check("rst_out", out_result, '0);
    repeat (2) @(negedge clk);
    q_exp.delete(); mc_vld = 0;
    aes_reset_n = 1; #1;
    check("rst_in_ready_low", 128'(in_ready), 128'd0);
    @(posedge clk); #1;
    check("rst_in_ready_rise", 128'(in_ready), 128'd1);
  endtask

  initial begin
    int i0, t;
    tbl[0] = '{K128, 1'b0, 1'b1, P0, C128};
    tbl[1] = '{K256, 1'b1, 1'b0, C256, P0};
    tbl[2] = '{K128, 1'b0, 1'b1, P0, C128};
    tbl[3] = '{K128, 1'b0, 1'b0, C128, ref_aes(K128, 1'b0, 1'b0, C128)};
    tbl[4] = '{K256, 1'b1, 1'b1, P0, ref_aes(K256, 1'b1, 1'b1, P0)};
    tbl[5] = '{~K256, 1'b1, 1'b0, 128'hdeadbeef, ref_aes(~K256, 1'b1, 1'b0, 128'hdeadbeef)};
    pool[0] = K128; pool[1] = K256; pool[2] = {8{32'h13579bdf}};
    do_reset();

    // table vectors, one job at a time
    for (int i = 0; i < 6; i++) begin
      send_job(tbl[i].key, tbl[i].kl, tbl[i].ed, tbl[i].blk, 1'b1);
      wait_out("vec_valid");
      pop_cmp($sformatf("vec%0d", i), tbl[i].exp);
    end
    check("vec_inits", 128'(init_cnt), 128'(exp_inits));

    // same AES-128 key twice after reset
    do_reset();
    i0 = init_cnt;
    send_job(K128, 1'b0, 1'b1, P0, 1'b1);
    send_job(K128, 1'b0, 1'b0, C128, 1'b1);
    wait_out("cache_valid");
    pop_one("cache_res0");
    wait_out("cache_valid");
    pop_one("cache_res1");
    check("cache_inits", 128'(init_cnt - i0), 128'(SAME_KEY_INITS));

    // backpressure: fill the FIFO, then pop one and pop the rest in order
    for (int i = 0; i < 4; i++) send_job(pool[i % 3], 1'(i), 1'(i >> 1), 128'(i * 7 + 1), 1'b1);
    wait_idle("bp_idle");
    check("bp_full_in_ready", 128'(in_ready), 128'd0);
    check("bp_full_out_valid", 128'(out_valid), 128'd1);
    @(negedge clk);
    pop_one("bp_pop0");
    check("bp_in_ready_after_pop", 128'(in_ready), 128'd1);
    for (int i = 1; i < 4; i++) begin @(negedge clk); pop_one("bp_pop"); end
    @(negedge clk);
    check("bp_empty", 128'(out_valid), 128'd0);

    // timeout: core never becomes ready after init
    hang = 1;
    send_job(pool[2], 1'b1, 1'b1, 128'h55, 1'b0);
    t = 0;
    @(negedge clk);
    while (!err && t < 100) begin @(negedge clk); t++; end
    check("tmo_err", 128'(err), 128'd1);
    check("tmo_no_result", 128'(out_valid), 128'd0);
    wait_idle("tmo_idle");
    check("tmo_busy", 128'(busy), 128'd0);
    hang = 0;
    send_job(pool[2], 1'b1, 1'b1, 128'h55, 1'b1);
    wait_out("tmo_next_valid");
    pop_one("tmo_next_res");
    check("tmo_err_sticky", 128'(err), 128'd1);
    check("tmo_inits", 128'(init_cnt), 128'(exp_inits));

    // reset during BLK_WAIT with two results queued
    do_reset();
    send_job(pool[1], 1'b1, 1'b0, 128'h1, 1'b1);
    send_job(pool[1], 1'b1, 1'b0, 128'h2, 1'b1);
    wait_idle("rst2_idle");
    check("rst2_queued", 128'(out_valid), 128'd1);
    send_job(pool[1], 1'b1, 1'b0, 128'h3, 1'b1);
    t = 0;
    while (!core_next && t < 50) begin @(negedge clk); t++; end
    check("rst2_next_seen", 128'(core_next), 128'd1);
    do_reset();
    i0 = init_cnt;
    send_job(pool[1], 1'b1, 1'b0, 128'h4, 1'b1);
    wait_out("rst2_valid");
    pop_one("rst2_res");
    check("rst2_reinit", 128'(init_cnt - i0), 128'd1);

    // random jobs with random consumer stalls
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          send_job(pool[$urandom_range(0, 2)], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   {$urandom, $urandom, $urandom, $urandom}, 1'b1);
        end
      end
      begin
        int got = 0, tc = 0;
        logic [127:0] e;
        while (got < 30 && tc < 5000) begin
          @(negedge clk); tc++;
          out_ready = 1'($urandom_range(0, 1));
          if (out_valid && out_ready) begin
            e = q_exp.size() != 0 ? q_exp.pop_front() : 'x;
            check("rand_res", out_result, e);
            got++;
          end
        end
        out_ready = 0;
        check("rand_count", 128'(got), 128'd30);
      end
    join
    check("rand_inits", 128'(init_cnt), 128'(exp_inits));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
